lsu_datamem: RTL

// - Parametrised successor data memory: byte-addressed, byte-enabled RAM with valid/ready request and response channels.
// - Sits between the core's MEM stage and on-chip data RAM; replaces the fixed 32-bit, always-ready memory.
// - Adds DATA_W=64 support (LD/SD/LWU), misalignment/illegal-op error responses, response backpressure, and an error counter.

---
 rtl/lsu_datamem.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_datamem.sv
// Byte-addressed, byte-enabled data RAM for the MEM stage with valid/ready request and
// response channels, misalignment/illegal-op error responses and a saturating error counter.
module lsu_datamem #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 12,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2:0]          req_funct3,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = ADDR_W - OFF_W;
  localparam int DEPTH = 2 ** IDX_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]          r_state;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic [ERRCNT_W-1:0] r_err_count;
  logic [2:0]          r_ld_funct3;
  logic [OFF_W-1:0]    r_ld_off;
  logic [DATA_W-1:0]   r_rd_word;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic              w_accept;
  logic              w_illegal;
  logic              w_misaligned;
  logic              w_err;
  logic              w_st_fire;
  logic              w_ld_fire;
  logic [IDX_W-1:0]  w_idx;
  logic [OFF_W-1:0]  w_off;
  logic [OFF_W-1:0]  w_lane_mask;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_wdata_rep;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_ext;
  logic              w_msb;
  logic              w_fill;
  int                w_nbits;

  assign req_ready = (r_state == S_IDLE) && rst_n;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign err_count = r_err_count;

  assign w_accept  = req_valid && req_ready;
  assign w_idx     = req_addr[ADDR_W-1:OFF_W];
  assign w_off     = req_addr[OFF_W-1:0];
  assign w_err     = w_illegal || w_misaligned;
  assign w_st_fire = w_accept && !w_err && req_write;
  assign w_ld_fire = w_accept && !w_err && !req_write;

  always_comb begin
    w_illegal = 1'b0;
    if (req_funct3 == 3'b111) w_illegal = 1'b1;
    if (req_write && req_funct3[2]) w_illegal = 1'b1;
    if ((DATA_W == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110))) w_illegal = 1'b1;
  end

  always_comb begin
    w_misaligned = 1'b0;
    w_lane_mask  = '0;
    case (req_funct3[1:0])
      2'd1: begin
        w_misaligned = req_addr[0];
        w_lane_mask  = OFF_W'(3'd1);
      end
      2'd2: begin
        w_misaligned = |req_addr[1:0];
        w_lane_mask  = OFF_W'(3'd3);
      end
      2'd3: begin
        w_misaligned = |req_addr[2:0];
        w_lane_mask  = OFF_W'(3'd7);
      end
      default: begin
        w_misaligned = 1'b0;
        w_lane_mask  = '0;
      end
    endcase
  end

  // Accesses are aligned, so a lane is enabled when it shares the access block with the
  // address, and lane i carries store byte (i mod access size).
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign w_be[gi] = (((OFF_W'(gi) ^ w_off) & ~w_lane_mask) == '0);
      assign w_wdata_rep[gi*8 +: 8] = req_wdata[{OFF_W'(gi) & w_lane_mask, 3'b000} +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_st_fire) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata_rep[b*8 +: 8];
      end
    end
    if (w_ld_fire) r_rd_word <= r_mem[w_idx];
  end

  assign w_shift = r_rd_word >> {r_ld_off, 3'b000};

  always_comb begin
    w_msb   = 1'b0;
    w_nbits = DATA_W;
    case (r_ld_funct3[1:0])
      2'd0: begin
        w_msb   = w_shift[7];
        w_nbits = 8;
      end
      2'd1: begin
        w_msb   = w_shift[15];
        w_nbits = 16;
      end
      2'd2: begin
        w_msb   = w_shift[31];
        w_nbits = 32;
      end
      default: begin
        w_msb   = w_shift[DATA_W-1];
        w_nbits = DATA_W;
      end
    endcase
    w_fill = !r_ld_funct3[2] && w_msb;
    w_ext  = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_ext[i] = (i < w_nbits) ? w_shift[i] : w_fill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_err_count <= '0;
      r_ld_funct3 <= 3'b000;
      r_ld_off    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_err) begin
              r_state     <= S_RESP;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
              if (r_err_count != '1) r_err_count <= r_err_count + ERRCNT_W'(1);
            end else if (req_write) begin
              r_state     <= S_RESP;
              r_rsp_err   <= 1'b0;
              r_rsp_rdata <= '0;
            end else begin
              r_state     <= S_READ;
              r_ld_funct3 <= req_funct3;
              r_ld_off    <= w_off;
            end
          end
        end
        S_READ: begin
          r_state     <= S_RESP;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= w_ext;
        end
        S_RESP: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
